gray_step_tracker: RTL and testbench



---
 rtl/gray_step_tracker.sv | 219 +++++++++++++++++++++
 tb/tb_gray_step_tracker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_tracker.sv
// -----------------------------------------------------------------------------
// gray_step_tracker
//
// Watches the Gray-coded output of an up/down counter and checks that it only
// ever moves one Gray step at a time. Each sample is converted to binary and
// compared with the last accepted value:
// - a +1 or -1 step (modulo 2^WIDTH) produces a one-cycle STEP pulse, updates
//   DIR and moves the signed net-position counter POS;
// - no change holds everything;
// - any other jump raises the sticky ERR flag.
//
// The first sample after reset or clr is taken as the reference value only.
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset (highest priority)
//   clr    : synchronous re-initialise (below reset)
//   G      : Gray code input, G[2]=O3, G[1]=O2, G[0]=O1
//   BIN    : registered binary value of the last accepted sample
//   STEP   : one-cycle pulse for every accepted legal step
//   DIR    : direction of the last legal step (1 = up, 0 = down)
//   POS    : signed two's-complement net step count, wraps modulo 2^CNT_W
//   ERR    : sticky illegal-transition flag
//   ERRCNT : (GRAY_TRACK_ERRCNT_EN only) saturating illegal-jump count
//
// Optional feature, macro GRAY_TRACK_ERRCNT_EN:
//   Adds ERRCNT. After an illegal jump the tracker stays in TRACK and adopts
//   the new value as its reference instead of parking in FAULT.
//   Without the macro the tracker freezes in FAULT until reset or clr.
// -----------------------------------------------------------------------------
module gray_step_tracker #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] BIN,
  output logic             STEP,
  output logic             DIR,
  output logic [CNT_W-1:0] POS,
  output logic             ERR
`ifdef GRAY_TRACK_ERRCNT_EN
  ,
  output logic [3:0]       ERRCNT
`endif
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
`ifdef GRAY_TRACK_ERRCNT_EN
  // With error counting there is no parking state.
  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;
`else
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;
`endif

  state_t state_reg, state_next;

  logic [WIDTH-1:0] bin_reg,  bin_next;
  logic             step_reg, step_next;
  logic             dir_reg,  dir_next;
  logic [CNT_W-1:0] pos_reg,  pos_next;
  logic             err_reg,  err_next;
`ifdef GRAY_TRACK_ERRCNT_EN
  logic [3:0]       errcnt_reg, errcnt_next;
`endif

  // ---------------------------------------------------------------------------
  // Gray to binary
  // Each binary bit is the XOR of all Gray bits at or above its position.
  // Writing it as a reduction keeps every bit a direct function of G rather
  // than chaining through neighbouring bits of the same vector.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] bin_g;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray2bin
      assign bin_g[gi] = ^G[WIDTH-1:gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Step classification against the last accepted value.
  // The sums are truncated to WIDTH bits, so 7->0 is +1 and 0->7 is -1.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] bin_inc;
  logic [WIDTH-1:0] bin_dec;
  logic             is_same;
  logic             is_up;
  logic             is_down;

  assign bin_inc = bin_reg + WIDTH'(1);
  assign bin_dec = bin_reg - WIDTH'(1);
  assign is_same = (bin_g == bin_reg);
  assign is_up   = (bin_g == bin_inc);
  assign is_down = (bin_g == bin_dec);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    step_next  = 1'b0;
    dir_next   = dir_reg;
    pos_next   = pos_reg;
    err_next   = err_reg;
`ifdef GRAY_TRACK_ERRCNT_EN
    errcnt_next = errcnt_reg;
`endif

    case (state_reg)
      INIT: begin
        // Reference sample only: never a step, POS untouched.
        bin_next   = bin_g;
        state_next = TRACK;
      end

      TRACK: begin
        if (is_same) begin
          // Nothing moved; STEP already defaults low.
        end else if (is_up) begin
          bin_next  = bin_g;
          step_next = 1'b1;
          dir_next  = 1'b1;
          pos_next  = pos_reg + CNT_W'(1);
        end else if (is_down) begin
          bin_next  = bin_g;
          step_next = 1'b1;
          dir_next  = 1'b0;
          pos_next  = pos_reg - CNT_W'(1);
        end else begin
          // Multi-step jump: flag it and take the new value as BIN.
          bin_next = bin_g;
          err_next = 1'b1;
`ifdef GRAY_TRACK_ERRCNT_EN
          if (errcnt_reg != 4'd15) begin
            errcnt_next = errcnt_reg + 4'd1;
          end
`else
          state_next = FAULT;
`endif
        end
      end

`ifndef GRAY_TRACK_ERRCNT_EN
      FAULT: begin
        // BIN keeps following the input so the next stage can still see
        // where the counter is; everything else is frozen.
        bin_next = bin_g;
      end
`endif

      default: begin
        state_next = INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. reset clears everything; clr restarts tracking but keeps the
  // last BIN and DIR so downstream logic does not see a spurious jump.
  // Either one discards whatever classification was pending on that edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= INIT;
      bin_reg   <= '0;
      step_reg  <= 1'b0;
      dir_reg   <= 1'b0;
      pos_reg   <= '0;
      err_reg   <= 1'b0;
`ifdef GRAY_TRACK_ERRCNT_EN
      errcnt_reg <= 4'd0;
`endif
    end else if (clr) begin
      state_reg <= INIT;
      step_reg  <= 1'b0;
      pos_reg   <= '0;
      err_reg   <= 1'b0;
`ifdef GRAY_TRACK_ERRCNT_EN
      errcnt_reg <= 4'd0;
`endif
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      step_reg  <= step_next;
      dir_reg   <= dir_next;
      pos_reg   <= pos_next;
      err_reg   <= err_next;
`ifdef GRAY_TRACK_ERRCNT_EN
      errcnt_reg <= errcnt_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from registers.
  // ---------------------------------------------------------------------------
  assign BIN  = bin_reg;
  assign STEP = step_reg;
  assign DIR  = dir_reg;
  assign POS  = pos_reg;
  assign ERR  = err_reg;
`ifdef GRAY_TRACK_ERRCNT_EN
  assign ERRCNT = errcnt_reg;
`endif

endmodule

// File: tb/tb_gray_step_tracker.sv
// -----------------------------------------------------------------------------
// tb_gray_step_tracker
//
// Drives gray_step_tracker with a directed sequence followed by randomised
// stimulus. Expected outputs come from a reference model that works on plain
// integers: Gray decoding by a lookup table built from b ^ (b >> 1), and step
// classification by the modular difference of consecutive binary values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gray_step_tracker;

  logic       clk;
  logic       reset;
  logic       clr;
  logic [2:0] G;
  logic [2:0] BIN;
  logic       STEP;
  logic       DIR;
  logic [7:0] POS;
  logic       ERR;
`ifdef GRAY_TRACK_ERRCNT_EN
  logic [3:0] ERRCNT;
`endif

  gray_step_tracker #(.WIDTH(3), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .G     (G),
    .BIN   (BIN),
    .STEP  (STEP),
    .DIR   (DIR),
    .POS   (POS),
    .ERR   (ERR)
`ifdef GRAY_TRACK_ERRCNT_EN
    ,
    .ERRCNT(ERRCNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int txn      = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         gray_to_bin[8];
  int         m_phase;          // 0 = waiting for reference, 1 = tracking, 2 = parked
  int         m_bin;
  bit         m_step;
  bit         m_dir;
  logic [7:0] m_pos;            // 8-bit so it wraps on its own
  bit         m_err;
  int         m_errcnt;

  function automatic logic [2:0] bin_to_gray(input int b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_bin    = 0;
    m_step   = 0;
    m_dir    = 0;
    m_pos    = 8'd0;
    m_err    = 0;
    m_errcnt = 0;
  endtask

  task automatic model_edge(input logic [2:0] g, input logic c, input logic r);
    int n;
    int d;
    if (r) begin
      model_reset();
      return;
    end
    if (c) begin
      m_phase  = 0;
      m_pos    = 8'd0;
      m_err    = 0;
      m_step   = 0;
      m_errcnt = 0;
      return;
    end
    n      = gray_to_bin[g];
    m_step = 0;
    if (m_phase == 0) begin
      m_bin   = n;
      m_phase = 1;
    end else if (m_phase == 1) begin
      d = (n - m_bin + 8) % 8;
      if (d == 1) begin
        m_bin = n; m_step = 1; m_dir = 1; m_pos = m_pos + 8'd1;
      end else if (d == 7) begin
        m_bin = n; m_step = 1; m_dir = 0; m_pos = m_pos - 8'd1;
      end else if (d != 0) begin
        m_bin = n;
        m_err = 1;
`ifdef GRAY_TRACK_ERRCNT_EN
        if (m_errcnt < 15) m_errcnt++;
`else
        m_phase = 2;
`endif
      end
    end else begin
      m_bin = n;
    end
  endtask

  task automatic compare_all();
    check("BIN",  32'(BIN),  32'(m_bin));
    check("STEP", 32'(STEP), 32'(m_step));
    check("DIR",  32'(DIR),  32'(m_dir));
    check("POS",  32'(POS),  32'(m_pos));
    check("ERR",  32'(ERR),  32'(m_err));
`ifdef GRAY_TRACK_ERRCNT_EN
    check("ERRCNT", 32'(ERRCNT), 32'(m_errcnt));
`endif
  endtask

  // One transaction: present inputs, clock them in, check just after the edge.
  task automatic drive(input logic [2:0] g, input logic c, input logic r);
    G     = g;
    clr   = c;
    reset = r;
    @(posedge clk);
    model_edge(g, c, r);
    #1;
    txn++;
    $display("txn %0d G=%b clr=%b rst=%b -> BIN=%0d STEP=%b DIR=%b POS=%0d ERR=%b",
             txn, g, c, r, BIN, STEP, DIR, $signed(POS), ERR);
    compare_all();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int         last_b;
  int         r;
  logic [2:0] g_rand;

  initial begin
    for (int b = 0; b < 8; b++) begin
      gray_to_bin[int'(bin_to_gray(b))] = b;
    end
    model_reset();
    G = 3'b000; clr = 1'b0; reset = 1'b1;

    // Reset state
    drive(3'b000, 1'b0, 1'b1);
    check("rst_BIN",  32'(BIN),  32'd0);
    check("rst_STEP", 32'(STEP), 32'd0);
    check("rst_POS",  32'(POS),  32'd0);
    check("rst_ERR",  32'(ERR),  32'd0);

    // Reference sample, then three up steps
    drive(3'b000, 1'b0, 1'b0);
    check("ref_STEP", 32'(STEP), 32'd0);
    drive(3'b001, 1'b0, 1'b0);
    check("up1_STEP", 32'(STEP), 32'd1);
    drive(3'b011, 1'b0, 1'b0);
    check("up2_STEP", 32'(STEP), 32'd1);
    drive(3'b010, 1'b0, 1'b0);
    check("up3_STEP", 32'(STEP), 32'd1);
    check("up3_DIR",  32'(DIR),  32'd1);
    check("up3_BIN",  32'(BIN),  32'd3);
    check("up3_POS",  32'(POS),  32'd3);

    // Up to 7, then wrap up to 0 and back down to 7
    drive(3'b110, 1'b0, 1'b0);
    drive(3'b111, 1'b0, 1'b0);
    drive(3'b101, 1'b0, 1'b0);
    drive(3'b100, 1'b0, 1'b0);
    check("at7_POS", 32'(POS), 32'd7);
    drive(3'b000, 1'b0, 1'b0);
    check("wrapup_STEP", 32'(STEP), 32'd1);
    check("wrapup_DIR",  32'(DIR),  32'd1);
    check("wrapup_BIN",  32'(BIN),  32'd0);
    drive(3'b100, 1'b0, 1'b0);
    check("wrapdn_DIR", 32'(DIR), 32'd0);
    check("wrapdn_BIN", 32'(BIN), 32'd7);
    check("wrapdn_POS", 32'(POS), 32'd7);

    // Hold at Gray 011
    drive(3'b011, 1'b1, 1'b0);
    drive(3'b011, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(3'b011, 1'b0, 1'b0);
      check("hold_STEP", 32'(STEP), 32'd0);
      check("hold_BIN",  32'(BIN),  32'd2);
      check("hold_POS",  32'(POS),  32'd0);
    end

    // Illegal jump 0 -> 2
    drive(3'b000, 1'b1, 1'b0);
    drive(3'b000, 1'b0, 1'b0);
    drive(3'b011, 1'b0, 1'b0);
    check("ill_ERR",  32'(ERR),  32'd1);
    check("ill_STEP", 32'(STEP), 32'd0);
    check("ill_POS",  32'(POS),  32'd0);
    drive(3'b010, 1'b0, 1'b0);
    check("ill2_BIN", 32'(BIN), 32'd3);
`ifndef GRAY_TRACK_ERRCNT_EN
    check("fault_STEP", 32'(STEP), 32'd0);
    check("fault_POS",  32'(POS),  32'd0);
`endif

    // clr while parked, with G=110
    drive(3'b110, 1'b1, 1'b0);
    check("clr_ERR", 32'(ERR), 32'd0);
    check("clr_POS", 32'(POS), 32'd0);
    drive(3'b110, 1'b0, 1'b0);
    check("clrref_BIN",  32'(BIN),  32'd4);
    check("clrref_STEP", 32'(STEP), 32'd0);
    drive(3'b111, 1'b0, 1'b0);
    check("clrup_STEP", 32'(STEP), 32'd1);
    check("clrup_POS",  32'(POS),  32'd1);

    // reset together with clr on a legal step edge (5 -> 6)
    drive(3'b101, 1'b1, 1'b1);
    check("rstclr_BIN",  32'(BIN),  32'd0);
    check("rstclr_STEP", 32'(STEP), 32'd0);
    check("rstclr_POS",  32'(POS),  32'd0);
    check("rstclr_DIR",  32'(DIR),  32'd0);
    drive(3'b101, 1'b0, 1'b0);
    check("postrst_STEP", 32'(STEP), 32'd0);
    check("postrst_BIN",  32'(BIN),  32'd6);

`ifdef GRAY_TRACK_ERRCNT_EN
    // 16 illegal jumps saturate the error counter
    drive(3'b000, 1'b1, 1'b0);
    drive(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive((i % 2 == 0) ? 3'b011 : 3'b000, 1'b0, 1'b0);
    end
    check("errcnt_sat", 32'(ERRCNT), 32'd15);
`endif

    // Randomised phase: mostly legal steps, some holds, random jumps,
    // occasional clr and reset.
    last_b = m_bin;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        drive(bin_to_gray(last_b), 1'b0, 1'b1);
      end else if (r < 7) begin
        drive(bin_to_gray(last_b), 1'b1, 1'b0);
      end else if (r < 67) begin
        last_b = ($urandom_range(0, 1) == 1) ? (last_b + 1) % 8 : (last_b + 7) % 8;
        drive(bin_to_gray(last_b), 1'b0, 1'b0);
      end else if (r < 87) begin
        drive(bin_to_gray(last_b), 1'b0, 1'b0);
      end else begin
        g_rand = 3'($urandom_range(0, 7));
        last_b = gray_to_bin[g_rand];
        drive(g_rand, 1'b0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
